// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder: the FSM state encoding and the
// ASCII codes for the two fixed output characters.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2,
      WORD = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code to ASCII table for letters and digits.
// Symbols sit in the LSBs with the first-keyed symbol highest; dot=0, dash=1.
module morse_lut #(
   parameter int MAX_SYM = 5,
   parameter int SYM_W   = $clog2(MAX_SYM + 1)
) (
   input  logic [MAX_SYM-1:0] pattern,
   input  logic [SYM_W-1:0]   sym_cnt,
   output logic [7:0]         ascii,
   output logic               known
);

   logic [7:0] key;

   // Codes never exceed five symbols, so only the low five pattern bits matter.
   always_comb begin
      ascii = 8'h00;
      known = 1'b0;
      key   = {3'(sym_cnt), pattern[4:0]};
      if (sym_cnt != '0 && sym_cnt <= SYM_W'(5)) begin
         known = 1'b1;
         case (key)
            {3'd1, 5'b00000}: ascii = "E";
            {3'd1, 5'b00001}: ascii = "T";
            {3'd2, 5'b00000}: ascii = "I";
            {3'd2, 5'b00001}: ascii = "A";
            {3'd2, 5'b00010}: ascii = "N";
            {3'd2, 5'b00011}: ascii = "M";
            {3'd3, 5'b00000}: ascii = "S";
            {3'd3, 5'b00001}: ascii = "U";
            {3'd3, 5'b00010}: ascii = "R";
            {3'd3, 5'b00011}: ascii = "W";
            {3'd3, 5'b00100}: ascii = "D";
            {3'd3, 5'b00101}: ascii = "K";
            {3'd3, 5'b00110}: ascii = "G";
            {3'd3, 5'b00111}: ascii = "O";
            {3'd4, 5'b00000}: ascii = "H";
            {3'd4, 5'b00001}: ascii = "V";
            {3'd4, 5'b00010}: ascii = "F";
            {3'd4, 5'b00100}: ascii = "L";
            {3'd4, 5'b00110}: ascii = "P";
            {3'd4, 5'b00111}: ascii = "J";
            {3'd4, 5'b01000}: ascii = "B";
            {3'd4, 5'b01001}: ascii = "X";
            {3'd4, 5'b01010}: ascii = "C";
            {3'd4, 5'b01011}: ascii = "Y";
            {3'd4, 5'b01100}: ascii = "Z";
            {3'd4, 5'b01101}: ascii = "Q";
            {3'd5, 5'b11111}: ascii = "0";
            {3'd5, 5'b01111}: ascii = "1";
            {3'd5, 5'b00111}: ascii = "2";
            {3'd5, 5'b00011}: ascii = "3";
            {3'd5, 5'b00001}: ascii = "4";
            {3'd5, 5'b00000}: ascii = "5";
            {3'd5, 5'b10000}: ascii = "6";
            {3'd5, 5'b11000}: ascii = "7";
            {3'd5, 5'b11100}: ascii = "8";
            {3'd5, 5'b11110}: ascii = "9";
            default:          known = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/morse_timed_decoder.sv
// Timed Morse key decoder: measures mark and gap lengths, assembles a symbol
// pattern per letter and emits one ASCII character (or a word space) per strobe.
module morse_timed_decoder
   import morse_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int DOT_MAX    = 3,
   parameter int DASH_MAX   = 12,
   parameter int LETTER_GAP = 3,
   parameter int WORD_GAP   = 7,
   parameter int MAX_SYM    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic [7:0] out,
   output logic       valid,
   output logic       err,
   output logic       busy
);

   localparam int SYM_W = $clog2(MAX_SYM + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   mark_cnt_q, mark_cnt_d, mark_inc;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d, gap_inc;
   logic [MAX_SYM-1:0] pat_q, pat_d;
   logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic               eflag_q, eflag_d;
   logic [7:0]         out_q, out_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic [7:0]         lut_ascii;
   logic               lut_known;

   morse_lut #(.MAX_SYM(MAX_SYM), .SYM_W(SYM_W)) u_lut (
      .pattern (pat_q),
      .sym_cnt (sym_cnt_q),
      .ascii   (lut_ascii),
      .known   (lut_known)
   );

   assign mark_inc = (&mark_cnt_q) ? mark_cnt_q : mark_cnt_q + CNT_W'(1);
   assign gap_inc  = (&gap_cnt_q)  ? gap_cnt_q  : gap_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      mark_cnt_d = mark_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      pat_d      = pat_q;
      sym_cnt_d  = sym_cnt_q;
      eflag_d    = eflag_q;
      out_d      = out_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (in) begin
               state_d    = MARK;
               mark_cnt_d = CNT_W'(1);
            end
         end
         MARK: begin
            if (in) begin
               mark_cnt_d = mark_inc;
               if (mark_inc > CNT_W'(DASH_MAX)) eflag_d = 1'b1;
            end else begin
               // An extra symbol poisons the letter instead of being stored.
               if (sym_cnt_q == SYM_W'(MAX_SYM)) begin
                  eflag_d = 1'b1;
               end else begin
                  pat_d     = {pat_q[MAX_SYM-2:0], (mark_cnt_q > CNT_W'(DOT_MAX))};
                  sym_cnt_d = sym_cnt_q + SYM_W'(1);
               end
               gap_cnt_d = CNT_W'(1);
               state_d   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q >= CNT_W'(LETTER_GAP)) begin
               valid_d   = 1'b1;
               out_d     = (lut_known && !eflag_q) ? lut_ascii : ASCII_UNKNOWN;
               err_d     = !lut_known || eflag_q;
               pat_d     = '0;
               sym_cnt_d = '0;
               eflag_d   = 1'b0;
               gap_cnt_d = gap_inc;
               // A key press on the emitting edge already starts the next letter.
               if (in) begin
                  state_d    = MARK;
                  mark_cnt_d = CNT_W'(1);
               end else begin
                  state_d = WORD;
               end
            end else if (in) begin
               state_d    = MARK;
               mark_cnt_d = CNT_W'(1);
            end else begin
               gap_cnt_d = gap_inc;
            end
         end
         WORD: begin
            if (gap_cnt_q >= CNT_W'(WORD_GAP)) begin
               valid_d = 1'b1;
               out_d   = ASCII_SPACE;
               state_d = in ? MARK : IDLE;
               if (in) mark_cnt_d = CNT_W'(1);
            end else if (in) begin
               state_d    = MARK;
               mark_cnt_d = CNT_W'(1);
            end else begin
               gap_cnt_d = gap_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         mark_cnt_q <= '0;
         gap_cnt_q  <= '0;
         pat_q      <= '0;
         sym_cnt_q  <= '0;
         eflag_q    <= 1'b0;
         out_q      <= 8'h00;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mark_cnt_q <= mark_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         pat_q      <= pat_d;
         sym_cnt_q  <= sym_cnt_d;
         eflag_q    <= eflag_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: doc/morse_timed_decoder.md
MORSE_TIMED_DECODER -- requirements
Module: morse_timed_decoder

Interface
REQ-001 The block SHALL take parameter CNT_W, default 16: width of the mark and gap cycle counters.
REQ-002 The block SHALL take parameter DOT_MAX, default 3: a mark of 1..DOT_MAX cycles is a dot.
REQ-003 The block SHALL take parameter DASH_MAX, default 12: a mark of DOT_MAX+1..DASH_MAX cycles is a dash; a longer mark is a stuck key.
REQ-004 The block SHALL take parameter LETTER_GAP, default 3: consecutive low cycles that end a letter.
REQ-005 The block SHALL take parameter WORD_GAP, default 7: consecutive low cycles, counted from the last mark, that end a word; WORD_GAP SHALL be greater than LETTER_GAP.
REQ-006 The block SHALL take parameter MAX_SYM, default 5: maximum symbols per character, with letters and digits supported.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port in, input, 1 bit: key level (1 = key down), synchronous to clk.
REQ-010 The block SHALL have port out, output, 8 bits: ASCII of the last decoded character.
REQ-011 The block SHALL have port valid, output, 1 bit: one-cycle strobe qualifying a new value on out.
REQ-012 The block SHALL have port err, output, 1 bit: high together with valid when the emitted character is invalid.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, MARK, GAP and WORD.
REQ-015 IDLE SHALL go to MARK when in=1, loading the mark count with 1; otherwise it SHALL remain in IDLE with no output, however long in stays low.
REQ-016 MARK SHALL increment the mark count each cycle in=1, saturating at 2^CNT_W-1; when the count exceeds DASH_MAX the letter error flag SHALL be set.
REQ-017 On the first in=0 sample in MARK, the block SHALL classify the mark (count<=DOT_MAX: dot=0; otherwise dash=1), shift it into the LSB of the MAX_SYM-bit pattern, increment the symbol count, load the gap count with 1, and enter GAP.
REQ-018 A symbol arriving when the symbol count already equals MAX_SYM SHALL set the letter error flag and SHALL NOT be shifted in.
REQ-019 In GAP, in=1 before the gap count reaches LETTER_GAP SHALL return to MARK with the same letter continuing; otherwise the gap count SHALL increment.
REQ-020 When the gap count reaches LETTER_GAP, the block SHALL, on that edge, present valid=1 for one cycle and enter WORD, then clear the pattern, the symbol count and the error flag.
REQ-021 The valid out value SHALL be the lookup result: 'A'-'Z' give 0x41-0x5A and '0'-'9' give 0x30-0x39.
REQ-022 An unknown code or a set error flag SHALL give out=0x3F ('?') with err=1.
REQ-023 In WORD, in=1 SHALL go to MARK as a new letter with no space emitted; when the gap count reaches WORD_GAP, the block SHALL emit out=0x20 with valid=1 (err=0) once and enter IDLE.
REQ-024 out SHALL hold its value between strobes.
REQ-025 valid and err SHALL be low in every cycle without an emission.
REQ-026 Emission latency SHALL be exactly LETTER_GAP clk edges after the falling mark sample.

Reset
REQ-027 While reset=0, asynchronously: state=IDLE, out=8'h00, valid=0, err=0, busy=0, and all counters, pattern and flags SHALL be zero.
REQ-028 Reset mid-letter SHALL discard the partial letter without emitting it.
REQ-029 Decoding SHALL restart on the first in=1 after reset deasserts.

Structure
REQ-030 Shared package morse_pkg SHALL hold the state encoding and the constants ASCII_SPACE=8'h20 and ASCII_UNKNOWN=8'h3F.
REQ-031 The code-to-ASCII table SHALL be a combinational sub-module morse_lut (inputs: pattern, symbol count; output: 8-bit ASCII plus a known flag).

Verification
REQ-032 With defaults, in=1 for 2 cycles, 0 for 1, 1 for 5, then 0 -> valid one cycle, 3 edges after the fall, out=0x41, err=0.
REQ-033 'S' (...) followed by 7 low cycles -> out=0x53 strobe, then out=0x20 strobe, busy=0 afterwards.
REQ-034 Five dots (.....) -> 0x35; six dots -> 0x3F with err=1.
REQ-035 A mark held 13 cycles, then released -> out=0x3F, err=1.
REQ-036 Reset pulsed low during the second symbol of 'K' -> no strobe; a subsequent 'E' -> 0x45.
REQ-037 A 5-cycle idle before the first mark -> no strobe, busy=0.
